// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// Segment patterns are active-high with bit7=a .. bit1=g, bit0=dp (dp never lit).
package seg_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SHOW = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    typedef struct packed {
        logic       blank;
        logic [3:0] val;
    } digit_t;

    localparam logic [7:0] AN_ALL_OFF = 8'hFF;
    localparam logic [7:0] SEG_NONE   = 8'h00;

    // Element 0 is the rightmost entry: index 0 -> 'FC', index 15 -> '8E'.
    localparam logic [15:0][7:0] SEG_TABLE = {
        8'h8E, 8'h9E, 8'h7A, 8'h9C, 8'h3E, 8'hEE, 8'hF6, 8'hFE,
        8'hE0, 8'hBE, 8'hB6, 8'h66, 8'hF2, 8'hDA, 8'h60, 8'hFC
    };

    function automatic logic [7:0] an_select(input logic [2:0] idx);
        return ~(8'd1 << idx);
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Hex digit to segment pattern; purely combinational, no handshake.
module seg_hex_decode
    import seg_scan_ctrl_pkg::*;
(
    input  logic [3:0] val,
    input  logic       blank,
    output logic [7:0] pattern
);

    assign pattern = blank ? SEG_NONE : SEG_TABLE[val];

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit display scanner: registered an/seg/scan_idx track the state entered on each edge.
// Writes are taken whenever wr_ready is high (OFF/SHOW); wr_ready drops for the DEAD cycle and in reset.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_cfg,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_idx,
    input  logic [3:0]       wr_val,
    input  logic             wr_blank,
    output logic [7:0]       an,
    output logic [7:0]       seg,
    output logic [2:0]       scan_idx
);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] cnt, cnt_nxt;
    logic [2:0]       idx_nxt;
    logic             wr_acc;
    digit_t           store [8];
    digit_t           shown;
    logic [7:0]       pattern;

    assign wr_ready = !rst && (state != ST_DEAD);
    assign wr_acc   = wr_valid && wr_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        idx_nxt   = scan_idx;
        if (!en) begin
            state_nxt = ST_OFF;
            cnt_nxt   = '0;
            idx_nxt   = 3'd0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = '0;
                    idx_nxt   = 3'd0;
                end
                ST_SHOW: begin
                    // >= rather than == so a div_cfg lowered mid-dwell ends the dwell at once.
                    if (cnt >= div_cfg) begin
                        state_nxt = ST_DEAD;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                ST_DEAD: begin
                    state_nxt = ST_SHOW;
                    cnt_nxt   = '0;
                    idx_nxt   = scan_idx + 3'd1;
                end
                default: begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                    idx_nxt   = 3'd0;
                end
            endcase
        end
    end

    // Bypass the write so a digit updated on this edge is displayed right after it.
    always_comb begin
        shown = store[idx_nxt];
        if (wr_acc && (wr_idx == idx_nxt)) begin
            shown.blank = wr_blank;
            shown.val   = wr_val;
        end
    end

    seg_hex_decode u_decode (
        .val     (shown.val),
        .blank   (shown.blank),
        .pattern (pattern)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_OFF;
            cnt      <= '0;
            scan_idx <= 3'd0;
            an       <= AN_ALL_OFF;
            seg      <= SEG_NONE;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            scan_idx <= idx_nxt;
            if (state_nxt == ST_SHOW) begin
                an  <= an_select(idx_nxt);
                seg <= pattern;
            end else begin
                an  <= AN_ALL_OFF;
                seg <= SEG_NONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                store[i] <= '{blank: 1'b1, val: 4'h0};
            end
        end else if (wr_acc) begin
            store[wr_idx] <= '{blank: wr_blank, val: wr_val};
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter DIV_W, default 16, width of refresh divider count.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 en  input  1  scan enable; 0 = display off.
REQ-005 div_cfg  input  DIV_W  digit dwell time in cycles minus one.
REQ-006 wr_valid  input  1  digit write request.
REQ-007 wr_ready  output  1  controller can accept a write this cycle.
REQ-008 wr_idx  input  3  target digit 0..7.
REQ-009 wr_val  input  4  hex value 0..F for target digit.
REQ-010 wr_blank  input  1  1 = target digit shows no segments.
REQ-011 an  output  8  digit enables, active-low, at most one bit low.
REQ-012 seg  output  8  segment pattern, bit7=a .. bit1=g, bit0=dp, active-high.
REQ-013 scan_idx  output  3  index of digit currently driven.

Function
REQ-014 Digit store: 8 entries of {blank, val[3:0]}; write occurs when wr_valid and wr_ready are both high on a clock edge.
REQ-015 wr_ready is high in states OFF and SHOW, low in DEAD and during reset.
REQ-016 Decode table (hex): 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=F6 A=EE b=3E C=9C d=7A E=9E F=8E; dp bit always 0.
REQ-017 FSM states: OFF, SHOW, DEAD.
REQ-018 OFF: an=FF, seg=00, scan_idx=0, dwell counter=0; en=1 moves to SHOW next cycle.
REQ-019 SHOW: an bit scan_idx low, all others high; seg = decode(val) of entry scan_idx, or 00 if its blank=1.
REQ-020 SHOW dwell counter increments each cycle; when counter >= div_cfg, next state DEAD and counter clears.
REQ-021 div_cfg=0 gives one-cycle SHOW; div_cfg changed mid-dwell takes effect immediately via the >= compare.
REQ-022 DEAD: exactly one cycle with an=FF, seg=00; scan_idx increments modulo 8 (7 wraps to 0); next state SHOW.
REQ-023 en=0 in any state: next state OFF, scan_idx returns to 0, counter clears; stored digits retained.
REQ-024 an, seg, scan_idx are registered; outputs reflect the state entered on the same edge.
REQ-025 A write to the digit currently shown is visible on seg on the cycle after the accepting edge.
REQ-026 Simultaneous write and end-of-dwell: the write is accepted, and the state advances to DEAD as normal.

Reset
REQ-027 rst high: state OFF, an=FF, seg=00, scan_idx=0, counter=0, wr_ready=0, all store entries {blank=1, val=0}.
REQ-028 rst asserted mid-scan overrides all other inputs the same edge; pending write is discarded.

Structure
REQ-029 Shared package holds FSM state enum, 16-entry decode table constant, an-all-off constant FF.
REQ-030 One sub-module seg_hex_decode: combinational 4-bit value plus blank to 8-bit pattern.

Verification
REQ-031 Reset, then en=1 with div_cfg=3 and no writes: an cycles FE,FF,FD,FF.. with 4-cycle dwell, seg=00 throughout.
REQ-032 Write digits 0..7 = 0,1,8,A,F,2,b,E with blank=0, div_cfg=0: seg sequence FC,60,FE,EE,8E,DA,3E,9E separated by 00 DEAD cycles; scan_idx wraps 7->0.
REQ-033 Write to shown digit 2 (val=5) mid-dwell: seg changes from prior value to B6 on next cycle, an unchanged.
REQ-034 Write held during DEAD cycle: wr_ready=0, no store change, write accepted on the following cycle.
REQ-035 en dropped at scan_idx=5: next cycle an=FF, seg=00, scan_idx=0; en reasserted restarts at digit 0 with stored values intact.
REQ-036 rst asserted mid-SHOW with wr_valid=1: outputs FF/00/0, subsequent scan shows all digits blank.
